// File: rtl/sqrt_pkg.sv
// Shared types and constants for the square-root request arbiter:
// FSM state encoding, default sizing and datapath widths.
package sqrt_pkg;

  localparam int N_REQ_DEFAULT   = 4;
  localparam int TIMEOUT_DEFAULT = 32;
  localparam int X_W             = 16;
  localparam int Y_W             = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  // Requester index width; never zero so a 1-bit id is still representable.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sqrt_arb_if.sv
// Bundle of requester, engine and response signals around sqrt_arb.
// slave = arbiter side, master = requesters/engine/consumer side.
interface sqrt_arb_if
  import sqrt_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT
) ();

  localparam int ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]     req_valid;
  logic [X_W*N_REQ-1:0] req_x;
  logic [N_REQ-1:0]     req_ready;

  logic                 eng_start;
  logic [X_W-1:0]       eng_x;
  logic                 eng_busy;
  logic [Y_W-1:0]       eng_y;

  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [Y_W-1:0]       rsp_y;
  logic                 rsp_err;
  logic                 arb_busy;

  modport slave (
    input  req_valid, req_x, eng_busy, eng_y,
    output req_ready, eng_start, eng_x, rsp_valid, rsp_id, rsp_y, rsp_err, arb_busy
  );

  modport master (
    output req_valid, req_x, eng_busy, eng_y,
    input  req_ready, eng_start, eng_x, rsp_valid, rsp_id, rsp_y, rsp_err, arb_busy
  );

endinterface

// File: rtl/sqrt_arb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after
// (last_grant + 1) mod N_REQ, wrapping around.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic             any_req,
  output logic [ID_W-1:0]  grant_id
);

  // Walk from the farthest offset down so the nearest requester wins.
  always_comb begin
    any_req  = |req;
    grant_id = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      if (req[ID_W'((int'(last_grant) + off) % N_REQ)]) begin
        grant_id = ID_W'((int'(last_grant) + off) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/sqrt_arb.sv
// Round-robin arbiter sharing one sqrt engine among N_REQ requesters.
// Optional engine watchdog enabled by defining SQRT_ARB_TIMEOUT_EN.
module sqrt_arb
  import sqrt_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  sqrt_arb_if.slave bus
);

  localparam int ID_W = id_width(N_REQ);

  state_t          state_reg, state_next;
  logic [ID_W-1:0] last_grant_reg;
  logic [ID_W-1:0] id_reg;
  logic [X_W-1:0]  x_reg;
  logic [ID_W-1:0] rsp_id_reg;
  logic [Y_W-1:0]  rsp_y_reg;

  logic            any_req;
  logic [ID_W-1:0] pick_id;
  logic            grant_en;
  logic            capture;
  logic            capture_err;
  logic [X_W-1:0]  x_slice [N_REQ];
  logic            timeout_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign x_slice[gi]       = bus.req_x[X_W*gi +: X_W];
      assign bus.req_ready[gi] = grant_en && (pick_id == ID_W'(gi));
    end
  endgenerate

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .req        (bus.req_valid),
    .last_grant (last_grant_reg),
    .any_req    (any_req),
    .grant_id   (pick_id)
  );

  // Grant is gated by rst so no requester believes it was accepted during reset.
  assign grant_en = (state_reg == IDLE) && any_req && !rst;

  always_comb begin
    state_next  = state_reg;
    capture     = 1'b0;
    capture_err = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.eng_busy) begin
          state_next = WAIT_DONE;
        end else if (timeout_hit) begin
          state_next  = RESP;
          capture     = 1'b1;
          capture_err = 1'b1;
        end
      end
      WAIT_DONE: begin
        // Normal completion takes precedence over a coincident timeout.
        if (!bus.eng_busy) begin
          state_next = RESP;
          capture    = 1'b1;
        end else if (timeout_hit) begin
          state_next  = RESP;
          capture     = 1'b1;
          capture_err = 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= ID_W'(N_REQ - 1);
      id_reg         <= '0;
      x_reg          <= '0;
      rsp_id_reg     <= '0;
      rsp_y_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_en) begin
        id_reg <= pick_id;
        x_reg  <= x_slice[pick_id];
      end
      if (capture) begin
        rsp_id_reg <= id_reg;
        rsp_y_reg  <= capture_err ? '0 : bus.eng_y;
      end
      if (state_reg == RESP) begin
        last_grant_reg <= id_reg;
      end
    end
  end

  assign bus.eng_start = (state_reg == ISSUE);
  assign bus.eng_x     = x_reg;
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_y     = rsp_y_reg;
  assign bus.arb_busy  = (state_reg != IDLE);

`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] to_cnt_reg;
  logic             rsp_err_reg;

  assign timeout_hit = (to_cnt_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_reg  <= '0;
      rsp_err_reg <= 1'b0;
    end else begin
      if (state_reg == ISSUE) begin
        to_cnt_reg <= '0;
      end else if (state_reg == WAIT_BUSY || state_reg == WAIT_DONE) begin
        to_cnt_reg <= to_cnt_reg + CNT_W'(1);
      end
      if (capture) begin
        rsp_err_reg <= capture_err;
      end
    end
  end

  assign bus.rsp_err = rsp_err_reg;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_hit    = 1'b0;
  assign bus.rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_arb.sv
// Bench for sqrt_arb: transaction-timeline model checked every cycle,
// a behavioural sqrt engine stub, and directed scenarios with literal results.
module tb_sqrt_arb;
  import sqrt_pkg::*;

  localparam int N  = 4;
  localparam int TO = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sqrt_arb_if #(.N_REQ(N)) bus ();

  sqrt_arb #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int isqrt(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Engine behaviour: >=1 busy cycles, -1 never busy, -2 busy forever.
  int eng_lat  = 3;
  bit auto_drop = 1'b1;

  logic [N-1:0]  obs_ready;
  logic          obs_start;
  logic          obs_rst;
  logic [15:0]   obs_x;

  int grant_q[$];
  int grant_s_q[$];
  int rsp_id_q[$];
  int rsp_y_q[$];
  int rsp_err_q[$];
  int rsp_s_q[$];

  // Model state: one transaction timeline at a time.
  int   s = 0;
  bit   model_ok = 1'b0;
  bit   rst_prev = 1'b0;
  bit   in_flight = 1'b0;
  int   m_last, g_s, g_id, g_y, g_err, due_s;
  logic [15:0] g_x;
  logic [15:0] exp_eng_x;
  int   exp_rsp_id, exp_rsp_y, exp_rsp_err;
  logic [N-1:0] exp_ready;
  bit   exp_start, exp_busy, exp_rspv;
  bit   do_grant;
  int   pick;

  always @(negedge clk) begin
    s++;
    obs_ready = bus.req_ready;
    obs_start = bus.eng_start;
    obs_rst   = rst;
    obs_x     = bus.eng_x;

    if (model_ok && bus.req_ready != '0) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_ready[i]) begin
          grant_q.push_back(i);
          grant_s_q.push_back(s);
          $display("grant  cycle=%0d id=%0d x=%0d", s, i, bus.req_x[16*i +: 16]);
        end
      end
    end
    if (model_ok && bus.rsp_valid === 1'b1) begin
      rsp_id_q.push_back(int'(bus.rsp_id));
      rsp_y_q.push_back(int'(bus.rsp_y));
      rsp_err_q.push_back(int'(bus.rsp_err));
      rsp_s_q.push_back(s);
      $display("resp   cycle=%0d id=%0d y=%0d err=%0d", s, bus.rsp_id, bus.rsp_y, bus.rsp_err);
    end

    if (rst_prev) begin
      model_ok    = 1'b1;
      in_flight   = 1'b0;
      m_last      = N - 1;
      exp_eng_x   = '0;
      exp_rsp_id  = 0;
      exp_rsp_y   = 0;
      exp_rsp_err = 0;
    end

    exp_ready = '0;
    exp_start = 1'b0;
    exp_busy  = 1'b0;
    exp_rspv  = 1'b0;
    do_grant  = 1'b0;
    if (in_flight) begin
      exp_busy = 1'b1;
      if (s == g_s + 1) begin
        exp_start = 1'b1;
        exp_eng_x = g_x;
      end
      if (s == due_s) begin
        exp_rspv    = 1'b1;
        exp_rsp_id  = g_id;
        exp_rsp_y   = g_y;
        exp_rsp_err = g_err;
      end
    end else if (model_ok && !rst && bus.req_valid != '0) begin
      pick = -1;
      for (int off = 1; off <= N; off++) begin
        if (pick < 0 && bus.req_valid[(m_last + off) % N]) pick = (m_last + off) % N;
      end
      exp_ready[pick] = 1'b1;
      do_grant = 1'b1;
    end

    if (model_ok) begin
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      chk("eng_start", 32'(bus.eng_start), 32'(exp_start));
      chk("arb_busy",  32'(bus.arb_busy),  32'(exp_busy));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rspv));
      chk("eng_x",     32'(bus.eng_x),     32'(exp_eng_x));
      chk("rsp_id",    32'(bus.rsp_id),    32'(exp_rsp_id));
      chk("rsp_y",     32'(bus.rsp_y),     32'(exp_rsp_y));
      chk("rsp_err",   32'(bus.rsp_err),   32'(exp_rsp_err));
    end

    if (in_flight && s == due_s) begin
      in_flight = 1'b0;
      m_last    = g_id;
    end
    if (do_grant) begin
      in_flight = 1'b1;
      g_s   = s;
      g_id  = pick;
      g_x   = bus.req_x[16*pick +: 16];
      g_y   = isqrt(int'(g_x));
      g_err = 0;
      if (eng_lat >= 1 && eng_lat + 1 <= TO) begin
        due_s = s + 3 + eng_lat;
      end else begin
`ifdef SQRT_ARB_TIMEOUT_EN
        due_s = s + 2 + TO;
        g_y   = 0;
        g_err = 1;
`else
        due_s = -1;
`endif
      end
    end
    rst_prev = rst;
  end

  // Sqrt engine stub; reacts to what was seen on the previous falling edge.
  int         rem = 0;
  logic [7:0] pend_y;
  always @(posedge clk) begin
    #1;
    if (obs_rst) begin
      bus.eng_busy = 1'b0;
      rem = 0;
    end else if (obs_start) begin
      if (eng_lat >= 1) begin
        bus.eng_busy = 1'b1;
        bus.eng_y    = 8'hA5;
        rem          = eng_lat;
        pend_y       = 8'(isqrt(int'(obs_x)));
      end else if (eng_lat == -2) begin
        bus.eng_busy = 1'b1;
        rem          = -1;
      end
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        bus.eng_busy = 1'b0;
        bus.eng_y    = pend_y;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_drop) bus.req_valid = bus.req_valid & ~obs_ready;
  endtask

  task automatic wait_rsp(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (rsp_id_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, 32'(rsp_id_q.size()), 32'(n));
  endtask

  task automatic wait_grant(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (grant_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, 32'(grant_q.size()), 32'(n));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    grant_q.delete();
    grant_s_q.delete();
    rsp_id_q.delete();
    rsp_y_q.delete();
    rsp_err_q.delete();
    rsp_s_q.delete();
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.eng_busy  = 1'b0;
    bus.eng_y     = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_arb_busy",  32'(bus.arb_busy),  32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_eng_x",     32'(bus.eng_x),     32'd0);
    chk("reset_rsp_y",     32'(bus.rsp_y),     32'd0);

    // Single requester, 144 -> 12, latency 3 + 3 busy cycles.
    eng_lat = 3;
    bus.req_x[15:0] = 16'd144;
    bus.req_valid   = 4'b0001;
    wait_rsp(1, 50, "single_rsp_timeout");
    if (rsp_id_q.size() == 1 && grant_q.size() == 1) begin
      chk("single_grant_id", 32'(grant_q[0]), 32'd0);
      chk("single_rsp_id",   32'(rsp_id_q[0]), 32'd0);
      chk("single_rsp_y",    32'(rsp_y_q[0]),  32'd12);
      chk("single_rsp_err",  32'(rsp_err_q[0]), 32'd0);
      chk("single_latency",  32'(rsp_s_q[0] - grant_s_q[0]), 32'd6);
    end else begin
      chk("single_grant_count", 32'(grant_q.size()), 32'd1);
    end

    // All four at once.
    do_reset();
    eng_lat = 2;
    bus.req_x = {16'd255, 16'd65535, 16'd1, 16'd0};
    bus.req_valid = 4'b1111;
    wait_rsp(4, 100, "all4_rsp_timeout");
    if (rsp_id_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("all4_rsp_id", 32'(rsp_id_q[i]), 32'(i));
      chk("all4_y0", 32'(rsp_y_q[0]), 32'd0);
      chk("all4_y1", 32'(rsp_y_q[1]), 32'd1);
      chk("all4_y2", 32'(rsp_y_q[2]), 32'd255);
      chk("all4_y3", 32'(rsp_y_q[3]), 32'd15);
    end

    // Requester 0 held valid with requester 2: grants must alternate.
    do_reset();
    eng_lat   = 1;
    auto_drop = 1'b0;
    bus.req_x = {16'd9, 16'd16, 16'd25, 16'd36};
    bus.req_valid = 4'b0101;
    wait_rsp(4, 100, "fair_rsp_timeout");
    bus.req_valid = '0;
    auto_drop = 1'b1;
    if (rsp_id_q.size() == 4) begin
      chk("fair_id0", 32'(rsp_id_q[0]), 32'd0);
      chk("fair_id1", 32'(rsp_id_q[1]), 32'd2);
      chk("fair_id2", 32'(rsp_id_q[2]), 32'd0);
      chk("fair_id3", 32'(rsp_id_q[3]), 32'd2);
      chk("fair_y1",  32'(rsp_y_q[1]),  32'd4);
    end
    repeat (4) tick();

    // Reset while the engine is busy: request is dropped silently.
    do_reset();
    eng_lat = 6;
    bus.req_x[31:16] = 16'd100;
    bus.req_valid    = 4'b0010;
    wait_grant(1, 20, "abort_grant_timeout");
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_arb_busy", 32'(bus.arb_busy), 32'd0);
    repeat (15) tick();
    chk("abort_no_rsp", 32'(rsp_id_q.size()), 32'd0);

`ifdef SQRT_ARB_TIMEOUT_EN
    // Engine stuck busy: error response after TIMEOUT wait cycles.
    do_reset();
    eng_lat = -2;
    bus.req_x[15:0] = 16'd144;
    bus.req_valid   = 4'b0001;
    wait_rsp(1, 100, "timeout_rsp_timeout");
    if (rsp_id_q.size() == 1 && grant_q.size() >= 1) begin
      chk("timeout_err",     32'(rsp_err_q[0]), 32'd1);
      chk("timeout_y",       32'(rsp_y_q[0]),   32'd0);
      chk("timeout_latency", 32'(rsp_s_q[0] - grant_s_q[0]), 32'd34);
    end
`else
    // Engine never raises busy: arbiter parks in WAIT_BUSY, no more grants.
    do_reset();
    eng_lat = -1;
    bus.req_x = {16'd49, 16'd0, 16'd81, 16'd0};
    bus.req_valid = 4'b1010;
    wait_grant(1, 20, "stuck_grant_timeout");
    repeat (40) tick();
    @(negedge clk);
    chk("stuck_grants",   32'(grant_q.size()), 32'd1);
    chk("stuck_arb_busy", 32'(bus.arb_busy),   32'd1);
    chk("stuck_no_rsp",   32'(rsp_id_q.size()), 32'd0);
`endif
    do_reset();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sqrt_arb.md
SQRT_ARB -- requirements
Module: sqrt_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter TIMEOUT, default 32, engine cycle limit used only under SQRT_ARB_TIMEOUT_EN.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset rst, synchronous, active-high.
REQ-005 req_valid  input  N_REQ  per-requester request pending.
REQ-006 req_x  input  16*N_REQ  per-requester radicand; slice i = bits [16i+15:16i].
REQ-007 req_ready  output  N_REQ  one-hot, one-cycle grant/accept pulse.
REQ-008 eng_start  output  1  start pulse to sqrt engine.
REQ-009 eng_x  output  16  radicand to engine.
REQ-010 eng_busy  input  1  engine busy.
REQ-011 eng_y  input  8  engine result, valid once busy has fallen.
REQ-012 rsp_valid  output  1  one-cycle response strobe.
REQ-013 rsp_id  output  clog2(N_REQ)  requester index of the response.
REQ-014 rsp_y  output  8  square-root result.
REQ-015 rsp_err  output  1  response is a timeout error (0 unless SQRT_ARB_TIMEOUT_EN).
REQ-016 arb_busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
REQ-018 IDLE: with any req_valid set, grant round-robin starting at (last_grant+1) mod N_REQ; assert req_ready[g] for exactly that cycle; latch req_x slice g and g; go to ISSUE.
REQ-019 IDLE with no req_valid: stay; all outputs idle.
REQ-020 ISSUE: eng_start=1 for one cycle, eng_x=latched value (eng_x held stable from ISSUE through WAIT_DONE); go to WAIT_BUSY.
REQ-021 WAIT_BUSY: on eng_busy=1 go to WAIT_DONE; otherwise stay.
REQ-022 WAIT_DONE: on eng_busy=0 capture eng_y into rsp_y and go to RESP.
REQ-023 RESP: rsp_valid=1, rsp_id=latched id for one cycle; update last_grant=id; return to IDLE.
REQ-024 Grant-to-rsp_valid latency = 3 + engine busy cycles; at most one request in flight.
REQ-025 req_valid deasserting while not granted is legal; no request is lost once req_ready has pulsed.
REQ-026 Requester i re-asserting immediately after its response is served only after all other pending requesters (fairness).
REQ-027 rsp_y/rsp_id hold their last value outside RESP; only rsp_valid qualifies them.

Reset
REQ-028 rst sets state=IDLE, last_grant=N_REQ-1 (first grant favors requester 0), req_ready=0, eng_start=0, eng_x=0, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_err=0, arb_busy=0.
REQ-029 rst mid-operation aborts the in-flight request without a response; the caller resets the engine simultaneously.

Configuration
REQ-030 With SQRT_ARB_TIMEOUT_EN defined: a counter clears on ISSUE and increments in WAIT_BUSY/WAIT_DONE; reaching TIMEOUT forces RESP with rsp_err=1, rsp_y=0.
REQ-031 Without SQRT_ARB_TIMEOUT_EN: no counter, rsp_err tied 0, WAIT states wait indefinitely.

Structure
REQ-032 Shared package sqrt_pkg holds the FSM state enum, default N_REQ, TIMEOUT, and widths 16 (radicand) and 8 (root).
REQ-033 Sub-module rr_arbiter (combinational round-robin pick from req vector and last_grant) is instantiated once.

Verification
REQ-034 Single req: req_valid=0001, x=144 -> req_ready=0001 one cycle; rsp_valid with id=0, y=12, err=0.
REQ-035 All four valid, x={0,1,65535,255} -> grant order 0,1,2,3; responses y=0,1,255,15, ids matching.
REQ-036 Requester 0 continuously valid plus requester 2 -> alternating grants 0,2,0,2.
REQ-037 rst asserted in WAIT_DONE -> next cycle state IDLE, rsp_valid never pulses, arb_busy=0.
REQ-038 SQRT_ARB_TIMEOUT_EN, TIMEOUT=32, eng_busy held 1 -> rsp_valid after 32 wait cycles with err=1, y=0.
REQ-039 Engine stub never raising busy, macro off -> FSM stays WAIT_BUSY, arb_busy=1, no further grants.
